// File: rtl/arbitro_inversor_bytes.sv
// Two-port round-robin arbiter in front of a shared byte-reordering engine.
// One registered output stage with valid/ready handshake, requester id tag and delivery counter.
module arbitro_inversor_bytes #(
    parameter int unsigned LARGURA   = 32,
    parameter int unsigned LARG_CONT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valido,
    input  logic [1:0]           req0_modo,
    input  logic [LARGURA-1:0]   req0_dado,
    output logic                 req0_pronto,
    input  logic                 req1_valido,
    input  logic [1:0]           req1_modo,
    input  logic [LARGURA-1:0]   req1_dado,
    output logic                 req1_pronto,
    output logic                 saida_valido,
    output logic [LARGURA-1:0]   saida_dado,
    output logic                 saida_id,
    input  logic                 saida_pronto,
    output logic [LARG_CONT-1:0] contagem
);

    localparam int NBYTES = int'(LARGURA / 8);
    localparam int NMEIAS = int'(LARGURA / 16);

    typedef enum logic {StVazio, StCheio} estado_t;

    estado_t              estado_q, estado_d;
    logic [LARGURA-1:0]   dado_q, dado_d;
    logic                 id_q, id_d;
    logic                 prio_q, prio_d;
    logic [LARG_CONT-1:0] cont_q, cont_d;
    logic                 livre, conc0, conc1, entrega;

    function automatic logic [LARGURA-1:0] reordena(input logic [1:0]         modo,
                                                    input logic [LARGURA-1:0] d);
        logic [LARGURA-1:0] r;
        r = d;
        case (modo)
            2'b01: begin
                for (int k = 0; k < NBYTES; k++) begin
                    r[8*k +: 8] = d[8*(NBYTES-1-k) +: 8];
                end
            end
            2'b10: begin
                for (int h = 0; h < NMEIAS; h++) begin
                    r[16*h +: 8]   = d[16*h+8 +: 8];
                    r[16*h+8 +: 8] = d[16*h +: 8];
                end
            end
            2'b11: begin
                for (int h = 0; h < NMEIAS; h++) begin
                    r[16*h +: 16] = d[16*(NMEIAS-1-h) +: 16];
                end
            end
            default: r = d;
        endcase
        return r;
    endfunction

    // Grant is purely combinational; a full register that drains this cycle can refill.
    always_comb begin
        livre   = (estado_q == StVazio) || saida_pronto;
        conc0   = !rst && livre && req0_valido && (!req1_valido || !prio_q);
        conc1   = !rst && livre && req1_valido && (!req0_valido || prio_q);
        entrega = (estado_q == StCheio) && saida_pronto;
    end

    always_comb begin
        estado_d = estado_q;
        dado_d   = dado_q;
        id_d     = id_q;
        prio_d   = prio_q;
        cont_d   = cont_q + LARG_CONT'(entrega);
        if (conc0 || conc1) begin
            dado_d   = conc1 ? reordena(req1_modo, req1_dado) : reordena(req0_modo, req0_dado);
            id_d     = conc1;
            estado_d = StCheio;
            prio_d   = conc0;
        end else if (entrega) begin
            estado_d = StVazio;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= StVazio;
            dado_q   <= '0;
            id_q     <= 1'b0;
            prio_q   <= 1'b0;
            cont_q   <= '0;
        end else begin
            estado_q <= estado_d;
            dado_q   <= dado_d;
            id_q     <= id_d;
            prio_q   <= prio_d;
            cont_q   <= cont_d;
        end
    end

    assign req0_pronto  = conc0;
    assign req1_pronto  = conc1;
    assign saida_valido = (estado_q == StCheio);
    assign saida_dado   = dado_q;
    assign saida_id     = id_q;
    assign contagem     = cont_q;

endmodule

// File: tb/tb_arbitro_inversor_bytes.sv
// Bench for arbitro_inversor_bytes: directed literal checks plus randomized traffic
// compared every cycle against a transaction-level model of the arbiter and output stage.
module tb_arbitro_inversor_bytes;

    localparam int unsigned W = 32;
    localparam int unsigned C = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valido, req1_valido, req0_pronto, req1_pronto;
    logic [1:0]   req0_modo, req1_modo;
    logic [W-1:0] req0_dado, req1_dado, saida_dado;
    logic         saida_valido, saida_id, saida_pronto;
    logic [C-1:0] contagem;

    int n_vec  = 0;
    int n_fail = 0;

    // Model state: what the DUT outputs must be during the current cycle.
    logic         model_ok = 1'b0;
    logic         m_valid, m_id, m_prio;
    logic [W-1:0] m_data;
    logic [C-1:0] m_cnt;

    arbitro_inversor_bytes #(.LARGURA(W), .LARG_CONT(C)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valido  (req0_valido),
        .req0_modo    (req0_modo),
        .req0_dado    (req0_dado),
        .req0_pronto  (req0_pronto),
        .req1_valido  (req1_valido),
        .req1_modo    (req1_modo),
        .req1_dado    (req1_dado),
        .req1_pronto  (req1_pronto),
        .saida_valido (saida_valido),
        .saida_dado   (saida_dado),
        .saida_id     (saida_id),
        .saida_pronto (saida_pronto),
        .contagem     (contagem)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_f(input logic [1:0] modo, input logic [W-1:0] d);
        logic [W-1:0] t;
        case (modo)
            2'b01:   return {<<8{d}};
            2'b10: begin
                t = {<<8{d}};
                return {<<16{t}};
            end
            2'b11:   return {<<16{d}};
            default: return d;
        endcase
    endfunction

    task automatic chk(input string nome, input logic [63:0] atual, input logic [63:0] esperado);
        n_vec++;
        if (atual !== esperado) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nome, atual, esperado, $time);
        end
    endtask

    task automatic ciclo();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [1:0] m0, input logic [W-1:0] d0,
                         input logic v1, input logic [1:0] m1, input logic [W-1:0] d1,
                         input logic p);
        req0_valido  = v0;
        req0_modo    = m0;
        req0_dado    = d0;
        req1_valido  = v1;
        req1_modo    = m1;
        req1_dado    = d1;
        saida_pronto = p;
    endtask

    // Compare process: checks at mid-cycle, then advances the model across the next edge.
    always @(negedge clk) begin
        logic livre, g0, g1;
        livre = !m_valid || saida_pronto;
        g0 = 1'b0;
        g1 = 1'b0;
        if (!rst && livre) begin
            if (req0_valido && req1_valido) begin
                g0 = (m_prio == 1'b0);
                g1 = (m_prio == 1'b1);
            end else begin
                g0 = req0_valido;
                g1 = req1_valido;
            end
        end
        if (model_ok) begin
            chk("req0_pronto", 64'(req0_pronto), 64'(g0));
            chk("req1_pronto", 64'(req1_pronto), 64'(g1));
            chk("saida_valido", 64'(saida_valido), 64'(m_valid));
            chk("saida_dado", 64'(saida_dado), 64'(m_data));
            chk("saida_id", 64'(saida_id), 64'(m_id));
            chk("contagem", 64'(contagem), 64'(m_cnt));
        end
        if (rst) begin
            model_ok = 1'b1;
            m_valid  = 1'b0;
            m_data   = '0;
            m_id     = 1'b0;
            m_prio   = 1'b0;
            m_cnt    = '0;
        end else if (model_ok) begin
            if (m_valid && saida_pronto) begin
                m_cnt   = m_cnt + 1'b1;
                m_valid = 1'b0;
            end
            if (g0 || g1) begin
                m_data  = g1 ? ref_f(req1_modo, req1_dado) : ref_f(req0_modo, req0_dado);
                m_id    = g1;
                m_valid = 1'b1;
                m_prio  = g0;
            end
        end
    end

    initial begin
        rst = 1'b1;
        drive(0, 2'b00, '0, 0, 2'b00, '0, 1'b0);
        repeat (2) ciclo();
        rst = 1'b0;
        chk("reset_valido", 64'(saida_valido), 64'd0);
        chk("reset_dado", 64'(saida_dado), 64'd0);
        chk("reset_contagem", 64'(contagem), 64'd0);

        // Full reversal through requester 0.
        drive(1, 2'b01, 32'h11223344, 0, 2'b00, '0, 1'b1);
        ciclo();
        chk("t1_dado", 64'(saida_dado), 64'h44332211);
        chk("t1_id", 64'(saida_id), 64'd0);
        chk("t1_valido", 64'(saida_valido), 64'd1);
        drive(0, 2'b00, '0, 0, 2'b00, '0, 1'b1);
        ciclo();
        chk("t1_contagem", 64'(contagem), 64'd1);

        // Requester 1, modes 10, 11, 00 back to back.
        drive(0, 2'b00, '0, 1, 2'b10, 32'h11223344, 1'b1);
        ciclo();
        chk("t2_modo10", 64'(saida_dado), 64'h22114433);
        chk("t2_id_a", 64'(saida_id), 64'd1);
        drive(0, 2'b00, '0, 1, 2'b11, 32'h11223344, 1'b1);
        ciclo();
        chk("t2_modo11", 64'(saida_dado), 64'h33441122);
        chk("t2_id_b", 64'(saida_id), 64'd1);
        drive(0, 2'b00, '0, 1, 2'b00, 32'h11223344, 1'b1);
        ciclo();
        chk("t2_modo00", 64'(saida_dado), 64'h11223344);
        chk("t2_id_c", 64'(saida_id), 64'd1);
        drive(0, 2'b00, '0, 0, 2'b00, '0, 1'b1);
        ciclo();

        // Both valid: grants alternate starting from req0.
        for (int i = 0; i < 4; i++) begin
            drive(1, 2'b00, 32'hB0B0B000 + W'(i), 1, 2'b00, 32'hA0A0A000 + W'(i), 1'b1);
            #1;
            chk("t3_pronto_onehot", 64'({req0_pronto, req1_pronto}),
                (i % 2 == 0) ? 64'd2 : 64'd1);
            ciclo();
            chk("t3_id", 64'(saida_id), 64'(i % 2));
        end

        // Stall while full.
        for (int i = 0; i < 3; i++) begin
            drive(1, 2'b01, 32'hDEADBEEF, 1, 2'b10, 32'hCAFEF00D, 1'b0);
            #1;
            chk("t4_pronto_zero", 64'({req0_pronto, req1_pronto}), 64'd0);
            ciclo();
            chk("t4_dado_stable", 64'(saida_dado), 64'hA0A0A003);
            chk("t4_id_stable", 64'(saida_id), 64'd1);
        end
        drive(0, 2'b00, '0, 0, 2'b00, '0, 1'b1);
        ciclo();
        chk("t4_contagem", 64'(contagem), 64'd8);
        chk("t4_drained", 64'(saida_valido), 64'd0);

        // Reset while full; priority back to req0.
        drive(0, 2'b00, '0, 1, 2'b01, 32'h01020304, 1'b0);
        ciclo();
        drive(0, 2'b00, '0, 0, 2'b00, '0, 1'b0);
        rst = 1'b1;
        ciclo();
        rst = 1'b0;
        chk("t5_valido", 64'(saida_valido), 64'd0);
        chk("t5_contagem", 64'(contagem), 64'd0);
        drive(1, 2'b00, 32'h55, 1, 2'b00, 32'h66, 1'b1);
        #1;
        chk("t5_tie_req0", 64'({req0_pronto, req1_pronto}), 64'd2);
        ciclo();
        chk("t5_id", 64'(saida_id), 64'd0);
        drive(0, 2'b00, '0, 0, 2'b00, '0, 1'b1);
        ciclo();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom), $urandom,
                  1'($urandom_range(0, 1)), 2'($urandom), $urandom,
                  ($urandom_range(0, 3) != 0));
            rst = ($urandom_range(0, 99) == 0);
            ciclo();
        end
        rst = 1'b0;

        // Counter wrap: 65535 deliveries then one more.
        rst = 1'b1;
        drive(0, 2'b00, '0, 0, 2'b00, '0, 1'b1);
        ciclo();
        rst = 1'b0;
        drive(1, 2'b01, 32'h0BADF00D, 0, 2'b00, '0, 1'b1);
        repeat (65535) ciclo();
        drive(0, 2'b00, '0, 0, 2'b00, '0, 1'b1);
        ciclo();
        chk("t6_all_ones", 64'(contagem), 64'hFFFF);
        drive(1, 2'b00, 32'h1, 0, 2'b00, '0, 1'b1);
        ciclo();
        drive(0, 2'b00, '0, 0, 2'b00, '0, 1'b1);
        ciclo();
        chk("t6_wrap", 64'(contagem), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
